// File: rtl/rf_alu_pkg.sv
// Shared opcodes, controller state encoding and parity helper for the
// sequential register-file/ALU execution core.
package rf_alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;

    // Widest datapath supported; narrower values are zero-extended for parity.
    localparam int PAR_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    function automatic logic even_parity(input logic [PAR_W-1:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/rf_regfile.sv
// Two-read/one-write register file with synchronous clear.
// Entry 0 always reads as zero and ignores writes.
module rf_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] r_addr_a,
    input  logic [ADDR_W-1:0] r_addr_b,
    output logic [DATA_W-1:0] r_data_a,
    output logic [DATA_W-1:0] r_data_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (w_addr != '0)) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data_a = (r_addr_a == '0) ? '0 : mem[r_addr_a];
    assign r_data_b = (r_addr_b == '0) ? '0 : mem[r_addr_b];

endmodule

// File: rtl/rf_alu_seq.sv
// Register file plus ALU behind a Start/Busy/Done controller.
// Shifts iterate one bit per cycle; result and flags register at write-back.
//
//   state  | meaning
//   S_IDLE | accept Start (snapshot operands) or Load (direct RF write)
//   S_EXEC | compute; shifts stay here for max(n,1) cycles
//   S_WB   | Done pulse; RF, ALU_F and flags update at the closing edge
module rf_alu_seq
    import rf_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic              Load,
    input  logic [3:0]        OP,
    input  logic [ADDR_W-1:0] R_Addr_A,
    input  logic [ADDR_W-1:0] R_Addr_B,
    input  logic [ADDR_W-1:0] W_Addr,
    input  logic [DATA_W-1:0] Input_Data,
    output logic [DATA_W-1:0] R_Data_A,
    output logic [DATA_W-1:0] R_Data_B,
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] ALU_F,
    output logic              ZF,
    output logic              CF,
    output logic              OF,
    output logic              SF,
    output logic              PF
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    state_t            state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] b_q;
    logic [SH_W-1:0]   cnt;
    logic              cf_t;
    logic              of_t;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] alu_f;
    logic              alu_cf;
    logic              alu_of;
    logic [DATA_W-1:0] sh_f;
    logic              sh_out;
    logic              is_shift;

    rf_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk      (Clk),
        .clr      (Clr),
        .we       (rf_we),
        .w_addr   (rf_wa),
        .w_data   (rf_wd),
        .r_addr_a (R_Addr_A),
        .r_addr_b (R_Addr_B),
        .r_data_a (R_Data_A),
        .r_data_b (R_Data_B)
    );

    // Write-back owns the write port; Load only lands when IDLE and Start is low.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = W_Addr;
        rf_wd = Input_Data;
        if (state == S_WB) begin
            rf_we = 1'b1;
            rf_wa = wa_q;
            rf_wd = acc;
        end else if ((state == S_IDLE) && Load && !Start) begin
            rf_we = 1'b1;
        end
    end

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, b_q};
        diff   = {1'b0, acc} - {1'b0, b_q};
        alu_f  = '0;
        alu_cf = 1'b0;
        alu_of = 1'b0;
        case (op_q)
            OP_AND: alu_f = acc & b_q;
            OP_OR:  alu_f = acc | b_q;
            OP_XOR: alu_f = acc ^ b_q;
            OP_NOR: alu_f = ~(acc | b_q);
            OP_ADD: begin
                alu_f  = sum[MSB:0];
                alu_cf = sum[DATA_W];
                alu_of = (acc[MSB] == b_q[MSB]) && (sum[MSB] != acc[MSB]);
            end
            OP_SUB: begin
                alu_f  = diff[MSB:0];
                alu_cf = diff[DATA_W];
                alu_of = (acc[MSB] != b_q[MSB]) && (diff[MSB] != acc[MSB]);
            end
            OP_SLT: begin
                alu_f[0] = $signed(acc) < $signed(b_q);
                alu_cf   = diff[DATA_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        sh_f   = acc;
        sh_out = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_f   = {acc[MSB-1:0], 1'b0};
                sh_out = acc[MSB];
            end
            OP_SRL: begin
                sh_f   = {1'b0, acc[MSB:1]};
                sh_out = acc[0];
            end
            OP_SRA: begin
                sh_f   = {acc[MSB], acc[MSB:1]};
                sh_out = acc[0];
            end
            default: ;
        endcase
    end

    assign is_shift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state <= S_IDLE;
            op_q  <= '0;
            wa_q  <= '0;
            acc   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            cf_t  <= 1'b0;
            of_t  <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            ALU_F <= '0;
            ZF    <= 1'b0;
            CF    <= 1'b0;
            OF    <= 1'b0;
            SF    <= 1'b0;
            PF    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        op_q  <= OP;
                        wa_q  <= W_Addr;
                        acc   <= R_Data_A;
                        b_q   <= R_Data_B;
                        cnt   <= R_Data_B[SH_W-1:0];
                        Busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!is_shift) begin
                        acc   <= alu_f;
                        cf_t  <= alu_cf;
                        of_t  <= alu_of;
                        Done  <= 1'b1;
                        state <= S_WB;
                    end else begin
                        of_t <= 1'b0;
                        if (cnt == '0) begin
                            cf_t  <= 1'b0;
                            Done  <= 1'b1;
                            state <= S_WB;
                        end else begin
                            // Shift counter runs down; terminal count 1 ends EXEC.
                            acc  <= sh_f;
                            cf_t <= sh_out;
                            cnt  <= cnt - SH_W'(1);
                            if (cnt == SH_W'(1)) begin
                                Done  <= 1'b1;
                                state <= S_WB;
                            end
                        end
                    end
                end
                S_WB: begin
                    ALU_F <= acc;
                    ZF    <= (acc == '0);
                    SF    <= acc[MSB];
                    PF    <= even_parity(PAR_W'(acc));
                    CF    <= cf_t;
                    OF    <= of_t;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
